// File: rtl/dcache_wb_burst_if.sv
// rtl/dcache_wb_burst_if.sv - core-side and memory-side signal bundle for dcache_wb_burst
//
// Groups the core data-port request/response and the memory-arbiter burst bus.
// slave  : the cache itself (takes core requests, drives the memory bus)
// master : the environment (core + memory arbiter)
interface dcache_wb_burst_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        d_cache_stall;
    logic        data_cache_req;
    logic        data_cache_wr;
    logic [31:0] data_cache_addr;
    logic [7:0]  data_cache_len;
    logic [31:0] data_cache_wdata;
    logic [31:0] data_cache_rdata;
    logic        data_cache_dok;

    modport slave (
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_cache_rdata, data_cache_dok,
        output data_sram_rdata, d_cache_stall,
        output data_cache_req, data_cache_wr, data_cache_addr, data_cache_len, data_cache_wdata
    );

    modport master (
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_cache_rdata, data_cache_dok,
        input  data_sram_rdata, d_cache_stall,
        input  data_cache_req, data_cache_wr, data_cache_addr, data_cache_len, data_cache_wdata
    );
endinterface

// File: rtl/dcache_wb_burst.sv
// rtl/dcache_wb_burst.sv - direct-mapped write-back write-allocate data cache with burst refill
//
// Ports:
//   clk    : clock
//   resetn : asynchronous active-low reset
//   bus    : dcache_wb_burst_if.slave
//            core side  : data_sram_en/wen/addr/wdata in, data_sram_rdata/d_cache_stall out
//            memory side: data_cache_req/wr/addr/len/wdata out, data_cache_rdata/dok in
module dcache_wb_burst #(
    parameter int          INDEX_W     = 7,
    parameter int          OFFSET_W    = 2,
    parameter logic [15:0] UNCACHED_HI = 16'h1faf
) (
    input  logic                 clk,
    input  logic                 resetn,
    dcache_wb_burst_if.slave     bus
);
    localparam int BEATS = 1 << OFFSET_W;
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 30 - INDEX_W - OFFSET_W;

    typedef enum logic [2:0] {S_IDLE, S_WB, S_LM, S_UCR, S_UCW, S_DONE} state_t;

    state_t r_state, w_next;

    logic [TAG_W-1:0]    r_tag  [LINES];
    logic [31:0]         r_data [LINES][BEATS];
    logic [LINES-1:0]    r_valid;
    logic [LINES-1:0]    r_dirty;
    logic [OFFSET_W-1:0] r_beat;
    logic [31:0]         r_save;

    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_index;
    logic [OFFSET_W-1:0] w_word;
    logic                w_uc;
    logic                w_hit;
    logic                w_last;
    logic                w_store_hit;
    logic                w_lm_beat;
    logic                w_unused;

    logic [31:0] w_rdata;
    logic        w_stall;
    logic        w_req;
    logic        w_wr;
    logic [31:0] w_addr;
    logic [7:0]  w_len;
    logic [31:0] w_wdata;

    assign w_tag   = bus.data_sram_addr[31:32-TAG_W];
    assign w_index = bus.data_sram_addr[OFFSET_W+INDEX_W+1:OFFSET_W+2];
    assign w_word  = bus.data_sram_addr[OFFSET_W+1:2];
    assign w_uc    = (bus.data_sram_addr[31:16] == UNCACHED_HI);
    assign w_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag) && !w_uc;
    assign w_last  = &r_beat;
    // Core addresses are word aligned; the byte bits carry no information.
    assign w_unused = ^bus.data_sram_addr[1:0];

    assign w_store_hit = (r_state == S_IDLE) && bus.data_sram_en && w_hit && (|bus.data_sram_wen);
    assign w_lm_beat   = (r_state == S_LM) && bus.data_cache_dok;

    always_comb begin
        w_next  = r_state;
        w_rdata = r_save;
        w_stall = 1'b0;
        w_req   = 1'b0;
        w_wr    = 1'b0;
        w_addr  = bus.data_sram_addr;
        w_len   = 8'd0;
        w_wdata = bus.data_sram_wdata;
        case (r_state)
            S_IDLE: begin
                w_rdata = r_data[w_index][w_word];
                if (bus.data_sram_en && !w_hit) begin
                    w_stall = 1'b1;
                    if (w_uc)
                        w_next = (|bus.data_sram_wen) ? S_UCW : S_UCR;
                    else if (r_valid[w_index] && r_dirty[w_index])
                        w_next = S_WB;
                    else
                        w_next = S_LM;
                end
            end
            S_WB: begin
                w_stall = 1'b1;
                w_req   = 1'b1;
                w_wr    = 1'b1;
                w_len   = 8'(BEATS - 1);
                w_addr  = {r_tag[w_index], w_index, r_beat, 2'b00};
                w_wdata = r_data[w_index][r_beat];
                // req stays high into LM; the drop of wr marks the new transaction.
                if (bus.data_cache_dok && w_last) w_next = S_LM;
            end
            S_LM: begin
                w_stall = 1'b1;
                w_req   = 1'b1;
                w_len   = 8'(BEATS - 1);
                w_addr  = {w_tag, w_index, r_beat, 2'b00};
                if (bus.data_cache_dok && w_last) w_next = S_IDLE;
            end
            S_UCR: begin
                w_stall = 1'b1;
                w_req   = 1'b1;
                if (bus.data_cache_dok) w_next = S_DONE;
            end
            S_UCW: begin
                w_stall = 1'b1;
                w_req   = 1'b1;
                w_wr    = 1'b1;
                if (bus.data_cache_dok) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.data_sram_rdata  = w_rdata;
    assign bus.d_cache_stall    = w_stall;
    assign bus.data_cache_req   = w_req;
    assign bus.data_cache_wr    = w_wr;
    assign bus.data_cache_addr  = w_addr;
    assign bus.data_cache_len   = w_len;
    assign bus.data_cache_wdata = w_wdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_dirty <= '0;
            r_beat  <= '0;
            r_save  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (w_store_hit) r_dirty[w_index] <= 1'b1;
                S_WB: if (bus.data_cache_dok) begin
                    // Beat counter wraps to zero on the last beat, ready for LM.
                    r_beat <= r_beat + 1'b1;
                    if (w_last) r_dirty[w_index] <= 1'b0;
                end
                S_LM: if (bus.data_cache_dok) begin
                    r_beat <= r_beat + 1'b1;
                    if (w_last) begin
                        r_valid[w_index] <= 1'b1;
                        r_dirty[w_index] <= 1'b0;
                    end
                end
                S_UCR: if (bus.data_cache_dok) r_save <= bus.data_cache_rdata;
                default: ;
            endcase
        end
    end

    // Data and tag storage carry no reset; validity is tracked by r_valid.
    always_ff @(posedge clk) begin
        if (w_store_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.data_sram_wen[b])
                    r_data[w_index][w_word][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
            end
        end
        if (w_lm_beat) r_data[w_index][r_beat] <= bus.data_cache_rdata;
        if (w_lm_beat && w_last) r_tag[w_index] <= w_tag;
    end
endmodule

// File: doc/dcache_wb_burst.md
Name: dcache_wb_burst

Overview:
- Parametrised direct-mapped, write-back, write-allocate data cache between the MIPS core data port and the memory arbiter.
- Successor to the single-word-line data cache: multi-word lines with burst refill and burst write-back, configurable geometry, and a configurable uncached window.
- Tag, valid, dirty and data arrays are internal flip-flop arrays with asynchronous read.

Parameters:
INDEX_W, 7, index bits; 2^INDEX_W lines
OFFSET_W, 2, word-offset bits; BEATS = 2^OFFSET_W words per line
UNCACHED_HI, 16'h1faf, addr[31:16] value marking the uncached window
TAG_W = 30-INDEX_W-OFFSET_W (derived localparam, not overridable)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
data_sram_en  in  1  core access request
data_sram_wen  in  4  byte write enables; 0 = load
data_sram_addr  in  32  byte address (word aligned)
data_sram_wdata  in  32  store data
data_sram_rdata  out  32  load data
d_cache_stall  out  1  core must hold its request
data_cache_req  out  1  memory transaction active
data_cache_wr  out  1  1 = write transaction
data_cache_addr  out  32  address of the current beat
data_cache_len  out  8  beats-1 (BEATS-1 cached, 0 uncached)
data_cache_wdata  out  32  write data of the current beat
data_cache_rdata  in  32  read data of the current beat
data_cache_dok  in  1  current beat done (one pulse per beat)

Behaviour:
- Address fields: tag = addr[31:32-TAG_W], index = addr[OFFSET_W+INDEX_W+1:OFFSET_W+2], word = addr[OFFSET_W+1:2].
- Access classes:
  - uc = (addr[31:16] == UNCACHED_HI).
  - hit = valid[index] && tag match && !uc.
- States: IDLE, WB, LM, UCR, UCW, DONE.
- Reset (async): state = IDLE, all valid and dirty bits = 0, beat counter = 0, data_cache_req = 0, data_cache_wr = 0, rdata save register = 0. Data and tag arrays are not reset.
- Reset mid-transaction abandons the burst; data_cache_req drops immediately.
- IDLE:
  - en && hit: d_cache_stall = 0 combinationally; load returns array word same cycle.
  - Store hit: merges wdata by byte enables into the array word at posedge and sets dirty.
  - en && !hit: d_cache_stall = 1 combinationally.
  - Next state: uc load -> UCR; uc store -> UCW; miss with dirty victim -> WB; miss with clean/invalid victim -> LM.
- WB:
  - data_cache_req = 1, data_cache_wr = 1, data_cache_len = BEATS-1.
  - addr = {victim_tag, index, beat, 2'b00}; wdata = victim word[beat].
  - Each dok increments beat. On the last dok: clear dirty, beat = 0, go to LM.
- LM:
  - data_cache_req = 1, data_cache_wr = 0, addr = {tag, index, beat, 2'b00}.
  - Each dok writes rdata into word[beat].
  - On the last dok: write tag, valid = 1, dirty = 0, go to IDLE. The replayed access then hits; a store sets dirty at that point (write-allocate).
- UCR: single beat at data_sram_addr. On dok: capture rdata into the save register, go to DONE.
- UCW: single beat, data_cache_wdata = data_sram_wdata. On dok go to DONE. The cache is not modified; an aliasing cached line is untouched.
- DONE: d_cache_stall = 0, data_sram_rdata = save register, next state IDLE. Lasts exactly one cycle.
- Stall rules: d_cache_stall = 1 in WB, LM, UCR and UCW regardless of dok.
- Bus rules:
  - data_cache_req is low in IDLE and DONE.
  - Between WB and LM, req is held high; the transaction boundary is marked by the change of data_cache_wr.
- dok arriving in IDLE or DONE is ignored.
- data_sram_rdata in IDLE with no hit is don't-care.
- The core keeps the address and data stable while stalled.

Test Plan:
- Cold load 0x0000_0010, defaults: WB skipped. LM beats at addresses 0x10, 0x14, 0x18, 0x1C with data A..D. Stall for 4 dok cycles plus IDLE entry, then rdata = A with stall = 0. Load 0x14 next -> B with no stall.
- Store 0x0000_0010 wen = 4'b0011 wdata = 0x1234_5678 on a line holding 0xAABB_CCDD -> word becomes 0xAABB_5678, dirty set, no memory traffic.
- Load 0x0000_0810 (same index, different tag) after the previous store:
  - WB: 4 write beats at 0x10..0x1C, beat 0 data 0xAABB_5678.
  - Then LM: 4 read beats at 0x810..0x81C.
  - Then hit.
- Uncached load 0x1FAF_0004 returning 0xDEAD_BEEF: len = 0, single beat, DONE cycle rdata = 0xDEAD_BEEF. A repeat of the same load misses again, since nothing is allocated.
- Uncached store 0x1FAF_0000 wdata = 0x55: one write beat with wdata = 0x55, cache state unchanged.
- Assert resetn low after beat 2 of an LM: req = 0 immediately. After release, the same load misses again (valid cleared) and performs the full 4-beat refill.
